// File: rtl/ball_engine.sv
// Pong ball engine: tick-gated motion with speed-up on paddle hits, wall and
// paddle bounces, miss detection, score keeping and serve/play/game-over sequencing.
module ball_engine #(
    parameter int X_W           = 8,
    parameter int Y_W           = 9,
    parameter int SIZE          = 10,
    parameter int MIN_X         = 0,
    parameter int MAX_X         = 239,
    parameter int MIN_Y         = 30,
    parameter int MAX_Y         = 290,
    parameter int START_X       = 120,
    parameter int START_Y       = 160,
    parameter int PADDLE_WIDTH  = 5,
    parameter int PADDLE_HEIGHT = 40,
    parameter int SPEED_MAX     = 4,
    parameter int SERVE_DELAY   = 60,
    parameter int SCORE_W       = 4,
    parameter int WIN_SCORE     = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               new_game,
    input  logic [X_W-1:0]     player_1_x,
    input  logic [X_W-1:0]     player_2_x,
    output logic [X_W-1:0]     ball_x,
    output logic [Y_W-1:0]     ball_y,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               hit,
    output logic               point_1,
    output logic               point_2,
    output logic [1:0]         state
);

    localparam int XE    = X_W + 1;
    localparam int YE    = Y_W + 1;
    localparam int SPD_W = $clog2(SPEED_MAX + 1);
    localparam int CNT_W = $clog2(SERVE_DELAY + 1);

    localparam logic [XE-1:0] LX_MIN  = XE'(MIN_X);
    localparam logic [XE-1:0] LX_MAX  = XE'(MAX_X);
    localparam logic [XE-1:0] LX_SIZE = XE'(SIZE);
    localparam logic [XE-1:0] LX_PH   = XE'(PADDLE_HEIGHT);

    localparam logic [YE-1:0] LY_MIN  = YE'(MIN_Y);
    localparam logic [YE-1:0] LY_MAX  = YE'(MAX_Y);
    localparam logic [YE-1:0] LY_SIZE = YE'(SIZE);
    localparam logic [YE-1:0] LY_PL   = YE'(MIN_Y + PADDLE_WIDTH);
    localparam logic [YE-1:0] LY_PR   = YE'(MAX_Y - PADDLE_WIDTH);

    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [X_W-1:0] X_TOP   = X_W'(MIN_X);
    localparam logic [X_W-1:0] X_BOT   = X_W'(MAX_X - SIZE);

    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
    localparam logic [Y_W-1:0] Y_PL    = Y_W'(MIN_Y + PADDLE_WIDTH);
    localparam logic [Y_W-1:0] Y_PR    = Y_W'(MAX_Y - PADDLE_WIDTH - SIZE);
    localparam logic [Y_W-1:0] Y_GL    = Y_W'(MIN_Y);
    localparam logic [Y_W-1:0] Y_GR    = Y_W'(MAX_Y - SIZE);

    localparam logic [SPD_W-1:0]   SPD_ONE   = SPD_W'(1);
    localparam logic [SPD_W-1:0]   SPD_TOP   = SPD_W'(SPEED_MAX);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_SERVE  = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SCORED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    state_t             r_state;
    logic [X_W-1:0]     r_ball_x;
    logic [Y_W-1:0]     r_ball_y;
    logic               r_dir_x;
    logic               r_dir_y;
    logic [SPD_W-1:0]   r_speed;
    logic [SCORE_W-1:0] r_score_1;
    logic [SCORE_W-1:0] r_score_2;
    logic [CNT_W-1:0]   r_serve_cnt;
    logic               r_hit;
    logic               r_point_1;
    logic               r_point_2;

    state_t             w_state_nxt;
    logic [X_W-1:0]     w_ball_x_nxt;
    logic [Y_W-1:0]     w_ball_y_nxt;
    logic               w_dir_x_nxt;
    logic               w_dir_y_nxt;
    logic [SPD_W-1:0]   w_speed_nxt;
    logic [SCORE_W-1:0] w_score_1_nxt;
    logic [SCORE_W-1:0] w_score_2_nxt;
    logic [CNT_W-1:0]   w_serve_cnt_nxt;
    logic               w_hit_nxt;
    logic               w_point_1_nxt;
    logic               w_point_2_nxt;

    logic [XE-1:0]      w_bx_e;
    logic [YE-1:0]      w_by_e;
    logic [XE-1:0]      w_sx;
    logic [YE-1:0]      w_sy;
    logic               w_ov_1;
    logic               w_ov_2;
    logic [SPD_W-1:0]   w_speed_up;
    logic [SCORE_W-1:0] w_score_1_inc;
    logic [SCORE_W-1:0] w_score_2_inc;

    // Extended-width operands keep the bound tests free of wrap-around
    assign w_bx_e = {1'b0, r_ball_x};
    assign w_by_e = {1'b0, r_ball_y};
    assign w_sx   = XE'(r_speed);
    assign w_sy   = YE'(r_speed);

    assign w_ov_1 = (w_bx_e + LX_SIZE >= {1'b0, player_1_x}) &&
                    (w_bx_e <= {1'b0, player_1_x} + LX_PH);
    assign w_ov_2 = (w_bx_e + LX_SIZE >= {1'b0, player_2_x}) &&
                    (w_bx_e <= {1'b0, player_2_x} + LX_PH);

    assign w_speed_up    = (r_speed >= SPD_TOP) ? SPD_TOP : r_speed + SPD_ONE;
    assign w_score_1_inc = r_score_1 + SCORE_W'(1);
    assign w_score_2_inc = r_score_2 + SCORE_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_ball_x_nxt    = r_ball_x;
        w_ball_y_nxt    = r_ball_y;
        w_dir_x_nxt     = r_dir_x;
        w_dir_y_nxt     = r_dir_y;
        w_speed_nxt     = r_speed;
        w_score_1_nxt   = r_score_1;
        w_score_2_nxt   = r_score_2;
        w_serve_cnt_nxt = r_serve_cnt;
        w_hit_nxt       = 1'b0;
        w_point_1_nxt   = 1'b0;
        w_point_2_nxt   = 1'b0;

        case (r_state)
            ST_SERVE: begin
                if (tick) begin
                    if (r_serve_cnt == CNT_LAST) begin
                        w_serve_cnt_nxt = '0;
                        w_state_nxt     = ST_PLAY;
                    end else begin
                        w_serve_cnt_nxt = r_serve_cnt + CNT_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    if (!r_dir_x) begin
                        if (w_bx_e <= LX_MIN + w_sx) begin
                            w_ball_x_nxt = X_TOP;
                            w_dir_x_nxt  = 1'b1;
                        end else begin
                            w_ball_x_nxt = r_ball_x - X_W'(r_speed);
                        end
                    end else begin
                        if (w_bx_e + LX_SIZE + w_sx >= LX_MAX) begin
                            w_ball_x_nxt = X_BOT;
                            w_dir_x_nxt  = 1'b0;
                        end else begin
                            w_ball_x_nxt = r_ball_x + X_W'(r_speed);
                        end
                    end

                    // A ball already past the paddle face runs on to the goal line
                    if (!r_dir_y) begin
                        if (w_by_e >= LY_PL && w_by_e <= LY_PL + w_sy && w_ov_1) begin
                            w_ball_y_nxt = Y_PL;
                            w_dir_y_nxt  = 1'b1;
                            w_hit_nxt    = 1'b1;
                            w_speed_nxt  = w_speed_up;
                        end else if (w_by_e <= LY_MIN + w_sy) begin
                            w_ball_y_nxt  = Y_GL;
                            w_point_2_nxt = 1'b1;
                            w_state_nxt   = ST_SCORED;
                        end else begin
                            w_ball_y_nxt = r_ball_y - Y_W'(r_speed);
                        end
                    end else begin
                        if (w_by_e + LY_SIZE <= LY_PR && w_by_e + LY_SIZE + w_sy >= LY_PR
                            && w_ov_2) begin
                            w_ball_y_nxt = Y_PR;
                            w_dir_y_nxt  = 1'b0;
                            w_hit_nxt    = 1'b1;
                            w_speed_nxt  = w_speed_up;
                        end else if (w_by_e + LY_SIZE + w_sy >= LY_MAX) begin
                            w_ball_y_nxt  = Y_GR;
                            w_point_1_nxt = 1'b1;
                            w_state_nxt   = ST_SCORED;
                        end else begin
                            w_ball_y_nxt = r_ball_y + Y_W'(r_speed);
                        end
                    end
                end
            end

            ST_SCORED: begin
                // dir_y is untouched by a miss, so it still names the side that conceded
                if (r_dir_y) begin
                    w_score_1_nxt = w_score_1_inc;
                    if (w_score_1_inc == SCORE_WIN) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_state_nxt  = ST_SERVE;
                        w_ball_x_nxt = X_START;
                        w_ball_y_nxt = Y_START;
                        w_speed_nxt  = SPD_ONE;
                        w_dir_y_nxt  = 1'b1;
                    end
                end else begin
                    w_score_2_nxt = w_score_2_inc;
                    if (w_score_2_inc == SCORE_WIN) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_state_nxt  = ST_SERVE;
                        w_ball_x_nxt = X_START;
                        w_ball_y_nxt = Y_START;
                        w_speed_nxt  = SPD_ONE;
                        w_dir_y_nxt  = 1'b0;
                    end
                end
            end

            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || new_game) begin
            r_state     <= ST_SERVE;
            r_ball_x    <= X_START;
            r_ball_y    <= Y_START;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_speed     <= SPD_ONE;
            r_score_1   <= '0;
            r_score_2   <= '0;
            r_serve_cnt <= '0;
            r_hit       <= 1'b0;
            r_point_1   <= 1'b0;
            r_point_2   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ball_x    <= w_ball_x_nxt;
            r_ball_y    <= w_ball_y_nxt;
            r_dir_x     <= w_dir_x_nxt;
            r_dir_y     <= w_dir_y_nxt;
            r_speed     <= w_speed_nxt;
            r_score_1   <= w_score_1_nxt;
            r_score_2   <= w_score_2_nxt;
            r_serve_cnt <= w_serve_cnt_nxt;
            r_hit       <= w_hit_nxt;
            r_point_1   <= w_point_1_nxt;
            r_point_2   <= w_point_2_nxt;
        end
    end

    assign ball_x  = r_ball_x;
    assign ball_y  = r_ball_y;
    assign score_1 = r_score_1;
    assign score_2 = r_score_2;
    assign hit     = r_hit;
    assign point_1 = r_point_1;
    assign point_2 = r_point_2;
    assign state   = r_state;

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: directed serve/shutout scenarios plus randomized play,
// every cycle compared against an integer game model.
module tb_ball_engine;

    localparam int SIZE = 10, MIN_X = 0, MAX_X = 239, MIN_Y = 30, MAX_Y = 290;
    localparam int START_X = 120, START_Y = 160, PW = 5, PH = 40;
    localparam int SPEED_MAX = 4, SERVE_DELAY = 60, WIN = 9;
    localparam int PL = MIN_Y + PW, PR = MAX_Y - PW;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       new_game = 1'b0;
    logic [7:0] player_1_x = 8'd100;
    logic [7:0] player_2_x = 8'd100;
    logic [7:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score_1, score_2;
    logic       hit, point_1, point_2;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // Game model: plain integers, states named by their output code
    int m_state, m_bx, m_by, m_dx, m_dy, m_spd, m_s1, m_s2, m_wait, m_scorer;
    int m_hit, m_p1, m_p2;

    ball_engine dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .new_game   (new_game),
        .player_1_x (player_1_x),
        .player_2_x (player_2_x),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_1    (score_1),
        .score_2    (score_2),
        .hit        (hit),
        .point_1    (point_1),
        .point_2    (point_2),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_bx = START_X; m_by = START_Y; m_dx = 1; m_dy = 1;
        m_spd = 1; m_s1 = 0; m_s2 = 0; m_wait = 0; m_scorer = 0;
        m_hit = 0; m_p1 = 0; m_p2 = 0;
    endtask

    task automatic model_step(input bit rst, input bit ng, input bit tk,
                              input int p1x, input int p2x);
        int s, nbx, nby, ndx, ndy, nsp, nst, pts;
        bit ov1, ov2;
        if (rst || ng) begin
            model_reset();
            return;
        end
        m_hit = 0; m_p1 = 0; m_p2 = 0;
        case (m_state)
            0: if (tk) begin
                if (m_wait == SERVE_DELAY - 1) begin m_wait = 0; m_state = 1; end
                else m_wait++;
            end
            1: if (tk) begin
                s = m_spd; nbx = m_bx; nby = m_by; ndx = m_dx; ndy = m_dy;
                nsp = m_spd; nst = 1;
                ov1 = (m_bx + SIZE >= p1x) && (m_bx <= p1x + PH);
                ov2 = (m_bx + SIZE >= p2x) && (m_bx <= p2x + PH);
                if (m_dx == 0) begin
                    if (m_bx <= MIN_X + s) begin nbx = MIN_X; ndx = 1; end
                    else nbx = m_bx - s;
                end else begin
                    if (m_bx + SIZE + s >= MAX_X) begin nbx = MAX_X - SIZE; ndx = 0; end
                    else nbx = m_bx + s;
                end
                if (m_dy == 0) begin
                    if (m_by >= PL && m_by <= PL + s && ov1) begin
                        nby = PL; ndy = 1; m_hit = 1;
                        nsp = (s + 1 > SPEED_MAX) ? SPEED_MAX : s + 1;
                    end else if (m_by <= MIN_Y + s) begin
                        nby = MIN_Y; m_p2 = 1; nst = 2; m_scorer = 2;
                    end else nby = m_by - s;
                end else begin
                    if (m_by + SIZE <= PR && m_by + SIZE >= PR - s && ov2) begin
                        nby = PR - SIZE; ndy = 0; m_hit = 1;
                        nsp = (s + 1 > SPEED_MAX) ? SPEED_MAX : s + 1;
                    end else if (m_by + SIZE >= MAX_Y - s) begin
                        nby = MAX_Y - SIZE; m_p1 = 1; nst = 2; m_scorer = 1;
                    end else nby = m_by + s;
                end
                m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy; m_spd = nsp; m_state = nst;
            end
            2: begin
                if (m_scorer == 1) begin m_s1++; pts = m_s1; end
                else begin m_s2++; pts = m_s2; end
                if (pts == WIN) m_state = 3;
                else begin
                    m_state = 0; m_bx = START_X; m_by = START_Y; m_spd = 1;
                    m_dy = (m_scorer == 1) ? 1 : 0;
                end
            end
            default: ;
        endcase
    endtask

    // One clock: inputs already applied, model follows the edge, outputs compared 1ns later
    task automatic step(input bit rst, input bit ng, input bit tk, input int p1x, input int p2x);
        reset = rst; new_game = ng; tick = tk;
        player_1_x = 8'(p1x); player_2_x = 8'(p2x);
        @(posedge clock);
        model_step(rst, ng, tk, p1x, p2x);
        #1;
        check("state", int'(state), m_state);
        check("ball_x", int'(ball_x), m_bx);
        check("ball_y", int'(ball_y), m_by);
        check("score_1", int'(score_1), m_s1);
        check("score_2", int'(score_2), m_s2);
        check("hit", int'(hit), m_hit);
        check("point_1", int'(point_1), m_p1);
        check("point_2", int'(point_2), m_p2);
    endtask

    function automatic int track(input int bx, input int slack);
        int p;
        p = bx - slack;
        if (p < 0) p = 0;
        if (p > 255) p = 255;
        return p;
    endfunction

    initial begin
        int guard;
        model_reset();

        // Reset, serve delay, first move, idle cycles
        step(1, 0, 0, 100, 100);
        step(1, 0, 0, 100, 100);
        check("rst_state", int'(state), 0);
        check("rst_ball_x", int'(ball_x), START_X);
        check("rst_ball_y", int'(ball_y), START_Y);
        for (int i = 0; i < SERVE_DELAY; i++) step(0, 0, 1, 100, 100);
        check("serve_to_play", int'(state), 1);
        check("serve_ball_x", int'(ball_x), 120);
        step(0, 0, 1, 100, 100);
        check("first_move_x", int'(ball_x), 121);
        check("first_move_y", int'(ball_y), 161);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 100, 100);
        check("idle_x", int'(ball_x), 121);
        check("idle_y", int'(ball_y), 161);

        // Shutout: player 1 tracks the ball, player 2 always out of reach
        guard = 0;
        while (m_state != 3 && guard < 20000) begin
            step(0, 0, 1, track(m_bx, 5), (m_bx >= 120) ? 0 : 200);
            guard++;
        end
        check("game_over", int'(state), 3);
        check("final_score_1", int'(score_1), WIN);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
        check("frozen_state", int'(state), 3);
        step(0, 1, 0, 100, 100);
        check("new_game_state", int'(state), 0);
        check("new_game_score_1", int'(score_1), 0);

        // Randomized play with occasional new_game/reset
        for (int i = 0; i < 16000; i++) begin
            bit tk, ng, rs;
            int p1, p2;
            tk = ($urandom_range(0, 3) != 0);
            ng = ($urandom_range(0, 2999) == 0);
            rs = ($urandom_range(0, 3999) == 0);
            p1 = ($urandom_range(0, 3) != 0) ? track(m_bx, $urandom_range(0, 48))
                                             : $urandom_range(0, 255);
            p2 = ($urandom_range(0, 3) != 0) ? track(m_bx, $urandom_range(0, 48))
                                             : $urandom_range(0, 255);
            step(rs, ng, tk, p1, p2);
        end

        // Reset mid-rally, then reset and new_game together
        guard = 0;
        while (!(m_state == 1 && m_spd >= 2) && guard < 6000) begin
            step(0, 0, 1, track(m_bx, 10), track(m_bx, 10));
            guard++;
        end
        check("rally_reached", int'(state), 1);
        step(1, 0, 1, 100, 100);
        check("mid_reset_x", int'(ball_x), START_X);
        check("mid_reset_y", int'(ball_y), START_Y);
        for (int i = 0; i < 70; i++) step(0, 0, 1, 100, 100);
        step(1, 1, 1, 100, 100);
        check("both_state", int'(state), 0);
        check("both_score_2", int'(score_2), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 100, 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
